// File: rtl/window3x3_stream.sv
// Streaming 3x3 neighbourhood generator with zero or replicate border padding.
// Two line buffers hold the previous two rows; six column taps give the left/centre columns.
module window3x3_stream #(
  parameter int DATA_W = 24,
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iBorderMode,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iPixel,
  output logic              oReady,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oWin0,
  output logic [DATA_W-1:0] oWin1,
  output logic [DATA_W-1:0] oWin2,
  output logic [DATA_W-1:0] oWin3,
  output logic [DATA_W-1:0] oWin4,
  output logic [DATA_W-1:0] oWin5,
  output logic [DATA_W-1:0] oWin6,
  output logic [DATA_W-1:0] oWin7,
  output logic [DATA_W-1:0] oWin8,
  output logic              oSol,
  output logic              oEof
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t r_state, w_nextState;

  logic [CW-1:0] r_inCol, r_cCol;
  logic [RW-1:0] r_inRow, r_cRow;
  logic          r_mode;
  logic          r_valid, r_sol, r_eof;
  logic [8:0][DATA_W-1:0] r_win;

  logic [DATA_W-1:0] r_lineA [WIDTH];
  logic [DATA_W-1:0] r_lineB [WIDTH];
  logic [DATA_W-1:0] r_t1, r_t2, r_m1, r_m2, r_b1, r_b2;

  logic w_slotFree, w_accept, w_step, w_load;
  logic w_inLastCol, w_inLastRow, w_cLastCol, w_cLastRow;
  logic [DATA_W-1:0] w_pix, w_rdA, w_rdB;
  logic [2:0] w_rowOut, w_colOut;
  logic [2:0][2:0][DATA_W-1:0] w_tap;
  logic [8:0][DATA_W-1:0] w_win;

  assign w_slotFree  = !r_valid || iReady;
  assign oReady      = (r_state != FLUSH) && w_slotFree;
  assign w_accept    = iValid && oReady;
  assign w_step      = w_accept || ((r_state == FLUSH) && w_slotFree);
  assign w_load      = w_slotFree && (((r_state == RUN) && iValid) || (r_state == FLUSH));
  assign w_pix       = (r_state == FLUSH) ? '0 : iPixel;
  assign w_inLastCol = (r_inCol == LAST_COL);
  assign w_inLastRow = (r_inRow == LAST_ROW);
  assign w_cLastCol  = (r_cCol == LAST_COL);
  assign w_cLastRow  = (r_cRow == LAST_ROW);
  assign w_rdA       = r_lineA[r_inCol];
  assign w_rdB       = r_lineB[r_inCol];

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_nextState = FILL;
      FILL:    if (w_accept && (r_inRow == RW'(1)) && (r_inCol == '0)) w_nextState = RUN;
      RUN:     if (w_accept && w_inLastCol && w_inLastRow) w_nextState = FLUSH;
      FLUSH:   if (w_load && w_cLastCol && w_cLastRow) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Line buffers and column taps are never reset; border masking hides any stale content.
  always_ff @(posedge iClk) begin
    if (w_step) begin
      r_lineA[r_inCol] <= w_pix;
      r_lineB[r_inCol] <= w_rdA;
      r_b1 <= w_pix;
      r_b2 <= r_b1;
      r_m1 <= w_rdA;
      r_m2 <= r_m1;
      r_t1 <= w_rdB;
      r_t2 <= r_t1;
    end
  end

  // Window rows: 0 = above centre, 2 = below; columns: 0 = left, 2 = right.
  assign w_tap[0] = {w_rdB, r_t1, r_t2};
  assign w_tap[1] = {w_rdA, r_m1, r_m2};
  assign w_tap[2] = {w_pix, r_b1, r_b2};
  assign w_rowOut = {w_cLastRow, 1'b0, (r_cRow == '0)};
  assign w_colOut = {w_cLastCol, 1'b0, (r_cCol == '0)};

  for (genvar gi = 0; gi < 3; gi++) begin : gRow
    for (genvar gj = 0; gj < 3; gj++) begin : gCol
      logic [DATA_W-1:0] w_repl;
      assign w_repl = w_rowOut[gi] ? (w_colOut[gj] ? w_tap[1][1] : w_tap[1][gj])
                                   : (w_colOut[gj] ? w_tap[gi][1] : w_tap[gi][gj]);
      assign w_win[gi*3+gj] = r_mode ? w_repl
                            : ((w_rowOut[gi] || w_colOut[gj]) ? '0 : w_tap[gi][gj]);
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= IDLE;
      r_inCol <= '0;
      r_inRow <= '0;
      r_cCol  <= '0;
      r_cRow  <= '0;
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
      r_sol   <= 1'b0;
      r_eof   <= 1'b0;
      r_win   <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == IDLE) && w_accept) r_mode <= iBorderMode;
      if (w_step) begin
        if (w_inLastCol) begin
          r_inCol <= '0;
          if (r_state != FLUSH) r_inRow <= w_inLastRow ? '0 : r_inRow + 1'b1;
        end else begin
          r_inCol <= r_inCol + 1'b1;
        end
      end
      // Flush advances the column pointer past the frame; realign it for the next frame.
      if ((r_state == FLUSH) && (w_nextState == IDLE)) r_inCol <= '0;
      if (w_load) begin
        r_win   <= w_win;
        r_valid <= 1'b1;
        r_sol   <= (r_cCol == '0);
        r_eof   <= w_cLastCol && w_cLastRow;
        if (w_cLastCol) begin
          r_cCol <= '0;
          r_cRow <= w_cLastRow ? '0 : r_cRow + 1'b1;
        end else begin
          r_cCol <= r_cCol + 1'b1;
        end
      end else if (iReady) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign oValid = r_valid;
  assign oSol   = r_sol;
  assign oEof   = r_eof;
  assign oWin0  = r_win[0];
  assign oWin1  = r_win[1];
  assign oWin2  = r_win[2];
  assign oWin3  = r_win[3];
  assign oWin4  = r_win[4];
  assign oWin5  = r_win[5];
  assign oWin6  = r_win[6];
  assign oWin7  = r_win[7];
  assign oWin8  = r_win[8];

endmodule

// File: tb/tb_window3x3_stream.sv
// Directed bench for window3x3_stream on a 5x4 frame of 8-bit pixels (value = base+k+1).
// Windows are captured on every transfer and scored in order against a position-based model.
module tb_window3x3_stream;

  localparam int DW = 8;
  localparam int WD = 5;
  localparam int HT = 4;

  logic          iClk;
  logic          iRst;
  logic          iBorderMode;
  logic          iValid;
  logic [DW-1:0] iPixel;
  logic          oReady;
  logic          oValid;
  logic          iReady;
  logic [DW-1:0] oWin0, oWin1, oWin2, oWin3, oWin4, oWin5, oWin6, oWin7, oWin8;
  logic          oSol;
  logic          oEof;

  window3x3_stream #(.DATA_W(DW), .WIDTH(WD), .HEIGHT(HT)) dut (
    .iClk(iClk), .iRst(iRst), .iBorderMode(iBorderMode),
    .iValid(iValid), .iPixel(iPixel), .oReady(oReady),
    .oValid(oValid), .iReady(iReady),
    .oWin0(oWin0), .oWin1(oWin1), .oWin2(oWin2), .oWin3(oWin3), .oWin4(oWin4),
    .oWin5(oWin5), .oWin6(oWin6), .oWin7(oWin7), .oWin8(oWin8),
    .oSol(oSol), .oEof(oEof)
  );

  logic [71:0] winBus;
  assign winBus = {oWin0, oWin1, oWin2, oWin3, oWin4, oWin5, oWin6, oWin7, oWin8};

  logic [73:0] cap [256];
  int          capCycle [256];
  int          capCount = 0;
  int          cycleCount = 0;
  logic [73:0] expWin [256];
  int          expCount = 0;
  int          checkedIdx = 0;
  int          acceptEdge [20];
  int          vecCount = 0;
  int          missCount = 0;
  bit          holdReady = 0;
  bit          randReady = 0;
  int          start, cnt;

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  always @(posedge iClk) cycleCount <= cycleCount + 1;

  always @(negedge iClk) begin
    if (iRst && oValid && iReady && capCount < 256) begin
      cap[capCount]      <= {oSol, oEof, winBus};
      capCycle[capCount] <= cycleCount;
      capCount           <= capCount + 1;
    end
  end

  initial begin
    iReady = 1'b1;
    forever begin
      @(posedge iClk);
      #1;
      iReady = holdReady ? 1'b0 : (randReady ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  task automatic checkOutput(input string tag, input logic [73:0] observed, input logic [73:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [73:0] packWin(bit s, bit e, int w0, int w1, int w2, int w3,
                                          int w4, int w5, int w6, int w7, int w8);
    return {s, e, 8'(w0), 8'(w1), 8'(w2), 8'(w3), 8'(w4), 8'(w5), 8'(w6), 8'(w7), 8'(w8)};
  endfunction

  function automatic logic [73:0] modelWin(int base, bit mode, int r, int c);
    logic [71:0] w;
    int rr, cc, v;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr < 0 || rr >= HT || cc < 0 || cc >= WD) begin
          if (mode) begin
            rr = (rr < 0) ? 0 : ((rr >= HT) ? HT - 1 : rr);
            cc = (cc < 0) ? 0 : ((cc >= WD) ? WD - 1 : cc);
            v = base + rr * WD + cc + 1;
          end else begin
            v = 0;
          end
        end else begin
          v = base + rr * WD + cc + 1;
        end
        w = {w[63:0], 8'(v)};
      end
    end
    return {(c == 0), (r == HT - 1 && c == WD - 1), w};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the last accepted pixel.
  task automatic applyStimulus(input int base, input bit mode, input bit randValid, input int nPix);
    int k, budget, nWin;
    nWin = (nPix == WD * HT) ? WD * HT : nPix - WD - 1;
    for (int n = 0; n < nWin; n++) begin
      expWin[expCount] = modelWin(base, mode, n / WD, n % WD);
      expCount++;
    end
    k = 0;
    budget = 0;
    while (k < nPix && budget < 1000) begin
      iValid      = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
      iPixel      = 8'(base + k + 1);
      iBorderMode = mode;
      @(negedge iClk);
      if (iValid && oReady) begin
        acceptEdge[k] = cycleCount + 1;
        k++;
      end
      @(posedge iClk);
      #1;
      budget++;
    end
    iValid = 1'b0;
    if (k < nPix) checkOutput("stimTimeout", 74'(k), 74'(nPix));
  endtask

  task automatic checkWindows();
    int budget;
    budget = 0;
    while (capCount < expCount && budget < 500) begin
      @(negedge iClk);
      #1;
      budget++;
    end
    repeat (5) @(negedge iClk);
    #1;
    checkOutput("winCount", 74'(capCount), 74'(expCount));
    for (int i = checkedIdx; i < expCount; i++)
      checkOutput($sformatf("win%0d", i), cap[i], expWin[i]);
    checkedIdx = expCount;
    @(posedge iClk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Valid"}, 74'(oValid), 74'(0));
    checkOutput({tag, "Win"}, 74'(winBus), 74'(0));
    checkOutput({tag, "Sol"}, 74'(oSol), 74'(0));
    checkOutput({tag, "Eof"}, 74'(oEof), 74'(0));
    checkOutput({tag, "Ready"}, 74'(oReady), 74'(1));
  endtask

  initial begin
    iRst = 1'b0;
    iValid = 1'b0;
    iPixel = '0;
    iBorderMode = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    checkResetOutputs("rst");
    iRst = 1'b1;
    @(posedge iClk);
    #1;

    // Zero padding, continuous stream: corners, latency and flush length.
    start = expCount;
    applyStimulus(0, 1'b0, 1'b0, 20);
    checkWindows();
    checkOutput("zeroFirst", cap[start], packWin(1, 0, 0, 0, 0, 0, 1, 2, 0, 6, 7));
    checkOutput("zeroLast", cap[start+19], packWin(0, 1, 14, 15, 0, 19, 20, 0, 0, 0, 0));
    checkOutput("latency", 74'(capCycle[start]), 74'(acceptEdge[6]));
    cnt = 0;
    for (int i = start; i < start + 20; i++) if (capCycle[i] > acceptEdge[19]) cnt++;
    checkOutput("flushWins", 74'(cnt), 74'(6));

    // Replicate padding on the same stream.
    start = expCount;
    applyStimulus(0, 1'b1, 1'b0, 20);
    checkWindows();
    checkOutput("replFirst", cap[start], packWin(1, 0, 1, 1, 2, 1, 1, 2, 6, 6, 7));
    checkOutput("replLast", cap[start+19], packWin(0, 1, 14, 15, 15, 19, 20, 20, 19, 20, 20));
    checkOutput("replRight", cap[start+9], packWin(0, 0, 4, 5, 5, 9, 10, 10, 14, 15, 15));

    // Hold iReady low for 10 cycles after the 8th window.
    start = expCount;
    fork
      applyStimulus(0, 1'b0, 1'b0, 20);
      begin
        cnt = 0;
        while (capCount < start + 8 && cnt < 200) begin
          @(negedge iClk);
          #1;
          cnt++;
        end
        checkOutput("bpReach8", 74'(capCount >= start + 8), 74'(1));
        holdReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge iClk);
          #1;
          checkOutput($sformatf("bpReady%0d", i), 74'(oReady), 74'(0));
          checkOutput($sformatf("bpValid%0d", i), 74'(oValid), 74'(1));
          checkOutput($sformatf("bpHold%0d", i), {oSol, oEof, winBus}, modelWin(0, 1'b0, 1, 3));
        end
        holdReady = 1'b0;
      end
    join
    checkWindows();

    // Back-to-back frames with the border mode toggled.
    start = expCount;
    applyStimulus(20, 1'b0, 1'b0, 20);
    applyStimulus(50, 1'b1, 1'b0, 20);
    checkWindows();
    cnt = 0;
    for (int i = start; i < start + 40; i++) if (cap[i][72]) cnt++;
    checkOutput("b2bEofCount", 74'(cnt), 74'(2));

    // Random valid/ready over three frames.
    randReady = 1'b1;
    applyStimulus(120, 1'b0, 1'b1, 20);
    applyStimulus(150, 1'b1, 1'b1, 20);
    applyStimulus(180, 1'b0, 1'b1, 20);
    checkWindows();
    randReady = 1'b0;
    @(posedge iClk);
    #1;

    // Abort a frame after 12 pixels, then run a clean frame.
    applyStimulus(0, 1'b1, 1'b0, 12);
    @(negedge iClk);
    #1;
    iRst = 1'b0;
    #1;
    checkResetOutputs("midRst");
    @(negedge iClk);
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    applyStimulus(200, 1'b0, 1'b0, 20);
    checkWindows();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
